// File: rtl/digit_scan_pkg.sv
// Shared constants for the two-digit scan controller: FSM state codes,
// the blank segment pattern and the BCD-to-7-segment lookup table.
package digit_scan_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF   = 3'd0;
  localparam state_t ST_SHOW1 = 3'd1;
  localparam state_t ST_GAP1  = 3'd2;
  localparam state_t ST_SHOW4 = 3'd3;
  localparam state_t ST_GAP4  = 3'd4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low; codes 10..15 are blank
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Display-side signal bundle of digit_scan_ctrl. `blink` exists only when
// DIGIT_BLINK_EN is defined.
interface digit_scan_ctrl_if;
  import digit_scan_pkg::*;

  // Plain level signals, no valid/ready: inputs are sampled every clock and
  // outputs are valid every cycle after reset.
  logic       enable;
  logic [3:0] digit1_code;
  logic [3:0] digit4_code;
  logic       sel;
  logic       onoff;
  logic [6:0] seg_out;
  state_t     dbg_state;
`ifdef DIGIT_BLINK_EN
  logic       blink;

  modport master (output enable, digit1_code, digit4_code, blink,
                  input  sel, onoff, seg_out, dbg_state);
  modport slave  (input  enable, digit1_code, digit4_code, blink,
                  output sel, onoff, seg_out, dbg_state);
`else
  modport master (output enable, digit1_code, digit4_code,
                  input  sel, onoff, seg_out, dbg_state);
  modport slave  (input  enable, digit1_code, digit4_code,
                  output sel, onoff, seg_out, dbg_state);
`endif

endinterface

// File: rtl/digit_scan_ctrl_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank.
module seg7_decoder
  import digit_scan_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_code];

endmodule

// File: rtl/digit_scan_ctrl.sv
// Two-digit (D1/D4) 7-segment refresh controller with blanking gaps.
// Optional whole-display blink when DIGIT_BLINK_EN is defined.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
`ifdef DIGIT_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 50
`endif
) (
  input  logic              clk,
  input  logic              rst,
  digit_scan_ctrl_if.slave  bus
);

  localparam int  CW      = cnt_width(DIGIT_CYCLES, BLANK_CYCLES);
  localparam bit  HAS_GAP = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLAST = HAS_GAP ? CW'(BLANK_CYCLES - 1) : '0;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_code;
  logic [6:0]    w_dec;
  logic          w_lit;
  logic          w_dark;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_code  <= '0;
    end else if (!bus.enable) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state <= ST_SHOW1;
          r_code  <= bus.digit1_code;
          r_cnt   <= '0;
        end
        ST_SHOW1: begin
          if (r_cnt == DLAST) begin
            r_cnt <= '0;
            if (HAS_GAP) begin
              r_state <= ST_GAP1;
            end else begin
              r_state <= ST_SHOW4;
              r_code  <= bus.digit4_code;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GAP1: begin
          if (r_cnt == BLAST) begin
            r_cnt   <= '0;
            r_state <= ST_SHOW4;
            r_code  <= bus.digit4_code;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_SHOW4: begin
          if (r_cnt == DLAST) begin
            r_cnt <= '0;
            if (HAS_GAP) begin
              r_state <= ST_GAP4;
            end else begin
              r_state <= ST_SHOW1;
              r_code  <= bus.digit1_code;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GAP4: begin
          if (r_cnt == BLAST) begin
            r_cnt   <= '0;
            r_state <= ST_SHOW1;
            r_code  <= bus.digit1_code;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DIGIT_BLINK_EN
  localparam int FW = cnt_width(BLINK_FRAMES, 0);
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_frame;
  logic          r_phase;
  logic          w_wrap;

  // A completed frame is the D4 slot (or its gap) handing back to SHOW1.
  assign w_wrap = bus.enable &&
                  ((r_state == ST_GAP4 && r_cnt == BLAST) ||
                   (!HAS_GAP && r_state == ST_SHOW4 && r_cnt == DLAST));

  always_ff @(posedge clk) begin
    if (rst || !bus.blink) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_frame == FLAST) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  // Phase can only be set while blink is high, so forcing on the register
  // alone keeps the outputs free of any input-to-output path.
  assign w_dark = r_phase;
`else
  assign w_dark = 1'b0;
`endif

  seg7_decoder u_dec (
    .i_code (r_code),
    .o_seg  (w_dec)
  );

  assign w_lit         = (r_state == ST_SHOW1) || (r_state == ST_SHOW4);
  assign bus.sel       = (r_state == ST_SHOW4) || (r_state == ST_GAP4);
  assign bus.onoff     = !w_lit || w_dark;
  assign bus.seg_out   = (w_lit && !w_dark) ? w_dec : SEG_BLANK;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: a gapped (BLANK=1) and a gapless (BLANK=0)
// instance checked every cycle against a frame-position model.
module tb_digit_scan_ctrl;

  localparam int D  = 4;
  localparam int BF = 2;
  localparam int BL [2] = '{1, 0};
  localparam bit SEL_T [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  localparam bit ONF_T [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic [3:0] d1 = 4'd0;
  logic [3:0] d4 = 4'd0;
`ifdef DIGIT_BLINK_EN
  logic       blink = 1'b0;
`endif

  digit_scan_ctrl_if bus_a ();
  digit_scan_ctrl_if bus_b ();

  assign bus_a.enable      = enable;
  assign bus_a.digit1_code = d1;
  assign bus_a.digit4_code = d4;
  assign bus_b.enable      = enable;
  assign bus_b.digit1_code = d1;
  assign bus_b.digit4_code = d4;
`ifdef DIGIT_BLINK_EN
  assign bus_a.blink = blink;
  assign bus_b.blink = blink;
`endif

  digit_scan_ctrl #(
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (1)
`ifdef DIGIT_BLINK_EN
    , .BLINK_FRAMES (BF)
`endif
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  digit_scan_ctrl #(
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (0)
`ifdef DIGIT_BLINK_EN
    , .BLINK_FRAMES (BF)
`endif
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // scoreboard counters
  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // model: position within the frame since scanning started
  bit         m_act [2] = '{0, 0};
  int         m_t   [2] = '{0, 0};
  logic [3:0] m_l1  [2] = '{0, 0};
  logic [3:0] m_l4  [2] = '{0, 0};
  int         m_fc  [2] = '{0, 0};
  bit         m_ph  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p;
      bit wrap;
      p    = 2 * (D + BL[k]);
      wrap = 1'b0;
      if (rst) begin
        m_act[k] = 1'b0;
        m_t[k]   = 0;
        m_l1[k]  = 4'd0;
        m_l4[k]  = 4'd0;
      end else if (!enable) begin
        m_act[k] = 1'b0;
      end else if (!m_act[k]) begin
        m_act[k] = 1'b1;
        m_t[k]   = 0;
        m_l1[k]  = d1;
      end else begin
        m_t[k] = (m_t[k] + 1) % p;
        wrap   = (m_t[k] == 0);
        if (m_t[k] == 0)         m_l1[k] = d1;
        if (m_t[k] == D + BL[k]) m_l4[k] = d4;
      end
`ifdef DIGIT_BLINK_EN
      if (rst || !blink) begin
        m_fc[k] = 0;
        m_ph[k] = 1'b0;
      end else if (wrap) begin
        m_fc[k] = m_fc[k] + 1;
        if (m_fc[k] == BF) begin
          m_fc[k] = 0;
          m_ph[k] = ~m_ph[k];
        end
      end
`endif
    end
  end

  task automatic model_out(input int k, output logic s, output logic o, output logic [6:0] g);
    int t;
    t = m_t[k];
    s = 1'b0;
    o = 1'b1;
    g = 7'h7F;
    if (m_act[k]) begin
      if (t < D) begin
        o = 1'b0; g = seg_of(m_l1[k]);
      end else if (t < D + BL[k]) begin
        s = 1'b0;
      end else if (t < 2 * D + BL[k]) begin
        s = 1'b1; o = 1'b0; g = seg_of(m_l4[k]);
      end else begin
        s = 1'b1;
      end
      if (m_ph[k]) begin
        o = 1'b1; g = 7'h7F;
      end
    end
  endtask

  // compare process: every cycle, both instances
  always @(negedge clk) begin
    if (cmp_on) begin
      logic s, o;
      logic [6:0] g;
      model_out(0, s, o, g);
      check("a_sel",   bus_a.sel,     s);
      check("a_onoff", bus_a.onoff,   o);
      check("a_seg",   bus_a.seg_out, g);
      model_out(1, s, o, g);
      check("b_sel",   bus_b.sel,     s);
      check("b_onoff", bus_b.onoff,   o);
      check("b_seg",   bus_b.seg_out, g);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    cmp_on = 1'b1;
    check("rst_sel",   bus_a.sel,     1'b0);
    check("rst_onoff", bus_a.onoff,   1'b1);
    check("rst_seg",   bus_a.seg_out, 7'h7F);

    rst = 1'b0; d1 = 4'd3; d4 = 4'd7; enable = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      check("frame_sel",   bus_a.sel,   SEL_T[i]);
      check("frame_onoff", bus_a.onoff, ONF_T[i]);
      check("frame_seg",   bus_a.seg_out,
            ONF_T[i] ? 7'h7F : (SEL_T[i] ? 7'b1111000 : 7'b0110000));
      step(1);
    end

    step(1);
    d1 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      check("midslot_seg", bus_a.seg_out, 7'b0110000);
      step(1);
    end
    step(6);
    check("next_show1_seg", bus_a.seg_out, 7'b0010010);

    step(7);
    enable = 1'b0;
    step(1);
    check("dis_onoff", bus_a.onoff,   1'b1);
    check("dis_sel",   bus_a.sel,     1'b0);
    check("dis_seg",   bus_a.seg_out, 7'h7F);
    step(2);
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      check("reen_onoff", bus_a.onoff, 1'b0);
      check("reen_sel",   bus_a.sel,   1'b0);
      step(1);
    end
    check("reen_gap", bus_a.onoff, 1'b1);

    rst = 1'b1;
    step(1);
    check("rstmid_onoff", bus_a.onoff,   1'b1);
    check("rstmid_seg",   bus_a.seg_out, 7'h7F);
    step(1);
    rst = 1'b0;
    step(1);
    check("rstrel_onoff", bus_a.onoff,   1'b0);
    check("rstrel_seg",   bus_a.seg_out, 7'b0010010);

    d4 = 4'd12;
    step(20);

`ifdef DIGIT_BLINK_EN
    enable = 1'b0;
    step(1);
    blink = 1'b1; enable = 1'b1; d1 = 4'd1; d4 = 4'd8;
    step(1);
    step(5);
    check("blink_lit", bus_a.onoff, 1'b0);
    step(20);
    check("blink_dark", bus_a.onoff, 1'b1);
    step(16);
    check("blink_relit", bus_a.onoff, 1'b0);
    step(20);
    blink = 1'b0;
    step(10);
`endif

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) d1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) d4 = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 59) != 0);
      rst    = ($urandom_range(0, 149) == 0);
`ifdef DIGIT_BLINK_EN
      if ($urandom_range(0, 79) == 0) blink = ~blink;
`endif
      step(1);
    end

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
